move_scheduler: RTL and testbench
=================================

Name: move_scheduler

Overview:
Turns the raw PS/2 keyboard byte history into frame-synchronous, one-cycle movement pulses (up/down/left/right) that drive screen_selector's move inputs. Tracks held/released state per direction key, resolves opposing keys, and schedules first move, initial repeat delay and auto-repeat on frame-tick boundaries. Sits between the keyboard receiver and the VGA screen path in top_vga.

Parameters:
KEY_UP, 8'h1D, make code for up (W)
KEY_DOWN, 8'h1B, make code for down (S)
KEY_LEFT, 8'h1C, make code for left (A)
KEY_RIGHT, 8'h23, make code for right (D)
REPEAT_DELAY, 20, frames between first move and first repeat (1..255)
REPEAT_PERIOD, 4, frames between subsequent repeats (1..255)

Ports:
clk  in  1  system/pixel clock
rst  in  1  reset; asynchronous, active-low (asserted at 0)
keycode  in  16  [15:8] previous PS/2 byte, [7:0] latest byte
frame_tick  in  1  one-cycle pulse at start of each frame
enable  in  1  when 0, no move pulses issued (key tracking continues)
move_up, move_down, move_left, move_right  out  1 each  one-cycle move pulses
held  out  4  registered held-key vector {up,down,left,right}

Behaviour:
- Reset (rst=0): held=0, all move_* = 0, FSM=IDLE, frame counter=0, keycode shadow=16'h0000.
- Key decode: event only when keycode != registered shadow; shadow updated every cycle.
  - latest byte in {F0,E0}: no event (prefix).
  - previous byte == F0 and latest matches a KEY_*: clear that held bit (break).
  - otherwise latest matches a KEY_*: set that held bit (make). Non-matching codes ignored.
  - held updates one cycle after keycode change.
- Effective direction dir[3:0] = held with up&down both set -> both cleared; left&right both set -> both cleared.
- FSM (advances only on frame_tick, except dir changes):
  - IDLE: dir==0. On dir!=0 -> FIRST.
  - FIRST: next frame_tick: pulse dir bits, counter=REPEAT_DELAY-1 -> DELAY.
  - DELAY: each frame_tick: counter==0 -> pulse dir, counter=REPEAT_PERIOD-1 -> REPEAT; else counter--.
  - REPEAT: each frame_tick: counter==0 -> pulse dir, reload REPEAT_PERIOD-1; else counter--.
  - Any state: dir change (incl. adding/removing a key) -> FIRST same cycle; dir==0 -> IDLE. Dir change has priority over frame_tick in the same cycle (tick consumed by FIRST transition, no pulse).
- Pulses: registered, asserted the cycle after the qualifying frame_tick, exactly one cycle wide; diagonal pulses are simultaneous. enable=0 masks pulses but FSM/counters still run.
- Counters 8-bit, unsigned, no wrap (reloaded before underflow).
- Reset mid-sequence: immediate return to reset values; pressed keys must be re-pressed.

Decomposition:
- Package move_pkg: default key codes, PS/2 prefix constants F0/E0, state enum (IDLE, FIRST, DELAY, REPEAT), direction bit indices.
- Sub-module key_tracker: keycode shadow, make/break decode, held register. move_scheduler instantiates it and owns arbitration, FSM, counters.

Test Plan:
- Reset: rst=0 with frame_ticks running -> all outputs 0, held=0; release rst -> still 0.
- Press W (keycode 16'h001D), 30 ticks, REPEAT_DELAY=20, PERIOD=4 -> move_up on tick 1, 21, 25, 29; no other outputs.
- Release: after W held, keycode 16'h1DF0 then 16'hF01D -> held[3]=0, no further pulses, FSM IDLE.
- Opposing: W then S held -> held=4'b1100, no pulses; release S -> move_up on next tick (FIRST restart).
- Diagonal/change: W held in REPEAT, press D -> next tick move_up and move_right same cycle; delay restarts (next pair 20 ticks later).
- enable=0 while W held 10 ticks -> no pulses; enable=1 -> pulses resume on the counter's existing schedule; unknown code 16'h0045 -> no held change.

Source files
------------

// File: rtl/move_pkg.sv
// rtl/move_pkg.sv - shared constants, state type and helpers for move_scheduler
// Purpose: default PS/2 make codes, PS/2 prefix bytes, scheduler state enum,
//          bit positions of the {up,down,left,right} direction vector and the
//          opposing-key resolution helper.
// Ports:   none (package).
package move_pkg;

  localparam logic [7:0] KEY_UP_DEF    = 8'h1D;
  localparam logic [7:0] KEY_DOWN_DEF  = 8'h1B;
  localparam logic [7:0] KEY_LEFT_DEF  = 8'h1C;
  localparam logic [7:0] KEY_RIGHT_DEF = 8'h23;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_DELAY  = 2'd2,
    ST_REPEAT = 2'd3
  } state_t;

  // Opposing keys cancel each other; the other axis is unaffected.
  function automatic logic [3:0] resolve_dir(input logic [3:0] h);
    logic [3:0] d;
    d = h;
    if (h[DIR_UP] && h[DIR_DOWN]) begin
      d[DIR_UP]   = 1'b0;
      d[DIR_DOWN] = 1'b0;
    end
    if (h[DIR_LEFT] && h[DIR_RIGHT]) begin
      d[DIR_LEFT]  = 1'b0;
      d[DIR_RIGHT] = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/key_tracker.sv
// rtl/key_tracker.sv - PS/2 make/break decoder keeping a held-key vector
// Purpose: watches the two-byte keycode history, detects a new byte by
//          comparing with a registered shadow copy, and sets/clears the
//          held bit of the matching direction key.
// Ports:   clk      - system clock
//          rst      - asynchronous reset, active low
//          keycode  - [15:8] previous PS/2 byte, [7:0] latest byte
//          held     - registered {up,down,left,right} held vector
module key_tracker
  import move_pkg::*;
#(
  parameter logic [7:0] KEY_UP    = KEY_UP_DEF,
  parameter logic [7:0] KEY_DOWN  = KEY_DOWN_DEF,
  parameter logic [7:0] KEY_LEFT  = KEY_LEFT_DEF,
  parameter logic [7:0] KEY_RIGHT = KEY_RIGHT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] keycode,
  output logic [3:0]  held
);

  logic [15:0] shadow_q;
  logic [3:0]  hit;
  logic [3:0]  held_d;
  logic        new_byte;
  logic        is_prefix;
  logic        is_break;

  always_comb begin
    hit            = 4'b0000;
    hit[DIR_UP]    = (keycode[7:0] == KEY_UP);
    hit[DIR_DOWN]  = (keycode[7:0] == KEY_DOWN);
    hit[DIR_LEFT]  = (keycode[7:0] == KEY_LEFT);
    hit[DIR_RIGHT] = (keycode[7:0] == KEY_RIGHT);
  end

  assign new_byte  = (keycode != shadow_q);
  assign is_prefix = (keycode[7:0] == PS2_BREAK) || (keycode[7:0] == PS2_EXT);
  assign is_break  = (keycode[15:8] == PS2_BREAK);

  always_comb begin
    held_d = held;
    if (new_byte && !is_prefix) begin
      if (is_break) held_d = held & ~hit;
      else          held_d = held | hit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= 16'h0000;
      held     <= 4'b0000;
    end else begin
      shadow_q <= keycode;
      held     <= held_d;
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// rtl/move_scheduler.sv - frame-synchronous movement pulse scheduler
// Purpose: resolves held direction keys into an effective direction and
//          issues one-cycle move pulses on frame ticks: first move, an
//          initial repeat delay, then periodic auto-repeat.
// Ports:   clk        - system/pixel clock
//          rst        - asynchronous reset, active low
//          keycode    - [15:8] previous PS/2 byte, [7:0] latest byte
//          frame_tick - one-cycle pulse at start of each frame
//          enable     - gates move pulses only; tracking and timing keep running
//          move_up/move_down/move_left/move_right - one-cycle move pulses
//          held       - registered {up,down,left,right} held vector
module move_scheduler
  import move_pkg::*;
#(
  parameter logic [7:0] KEY_UP        = KEY_UP_DEF,
  parameter logic [7:0] KEY_DOWN      = KEY_DOWN_DEF,
  parameter logic [7:0] KEY_LEFT      = KEY_LEFT_DEF,
  parameter logic [7:0] KEY_RIGHT     = KEY_RIGHT_DEF,
  parameter int         REPEAT_DELAY  = 20,
  parameter int         REPEAT_PERIOD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] keycode,
  input  logic        frame_tick,
  input  logic        enable,
  output logic        move_up,
  output logic        move_down,
  output logic        move_left,
  output logic        move_right,
  output logic [3:0]  held
);

  localparam logic [7:0] DELAY_LOAD  = 8'(REPEAT_DELAY - 1);
  localparam logic [7:0] PERIOD_LOAD = 8'(REPEAT_PERIOD - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] dir;
  logic [3:0] dir_q;
  logic       dir_changed;
  logic       fire;
  logic [3:0] pulse_d;
  logic [3:0] pulse_q;

  key_tracker #(
    .KEY_UP   (KEY_UP),
    .KEY_DOWN (KEY_DOWN),
    .KEY_LEFT (KEY_LEFT),
    .KEY_RIGHT(KEY_RIGHT)
  ) u_key_tracker (
    .clk    (clk),
    .rst    (rst),
    .keycode(keycode),
    .held   (held)
  );

  assign dir         = resolve_dir(held);
  assign dir_changed = (dir != dir_q);

  // State, counter, last-seen direction and pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      dir_q   <= 4'b0000;
      pulse_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir;
      pulse_q <= pulse_d;
    end
  end

  // Next state. A direction change wins over a coincident frame tick, so the
  // tick is swallowed and the first move waits for the following tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (dir_changed) begin
      state_d = (dir == 4'b0000) ? ST_IDLE : ST_FIRST;
    end else if (frame_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (dir != 4'b0000) state_d = ST_FIRST;
        end
        ST_FIRST: begin
          cnt_d   = DELAY_LOAD;
          state_d = ST_DELAY;
        end
        ST_DELAY, ST_REPEAT: begin
          if (cnt_q == 8'd0) begin
            cnt_d   = PERIOD_LOAD;
            state_d = ST_REPEAT;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs. enable only masks the pulse; the schedule itself keeps running.
  always_comb begin
    fire = 1'b0;
    if (frame_tick && !dir_changed) begin
      case (state_q)
        ST_FIRST:            fire = 1'b1;
        ST_DELAY, ST_REPEAT: fire = (cnt_q == 8'd0);
        default:             fire = 1'b0;
      endcase
    end
    pulse_d = (fire && enable) ? dir : 4'b0000;
  end

  assign move_up    = pulse_q[DIR_UP];
  assign move_down  = pulse_q[DIR_DOWN];
  assign move_left  = pulse_q[DIR_LEFT];
  assign move_right = pulse_q[DIR_RIGHT];

endmodule

// File: tb/tb_move_scheduler.sv
// tb/tb_move_scheduler.sv - self-checking bench for move_scheduler
module tb_move_scheduler;

  localparam int D = 20;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] keycode;
  logic        frame_tick;
  logic        enable;
  logic        move_up, move_down, move_left, move_right;
  logic [3:0]  held;
  logic [3:0]  mv;

  int total = 0;
  int bad   = 0;

  logic [7:0]  key_codes [4];
  logic [3:0]  m_held;
  logic [15:0] m_last_kc;
  logic [3:0]  m_dir;
  int          m_n;
  logic        m_en;

  always #5 clk = ~clk;

  assign mv = {move_up, move_down, move_left, move_right};

  move_scheduler #(
    .REPEAT_DELAY (D),
    .REPEAT_PERIOD(P)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .keycode   (keycode),
    .frame_tick(frame_tick),
    .enable    (enable),
    .move_up   (move_up),
    .move_down (move_down),
    .move_left (move_left),
    .move_right(move_right),
    .held      (held)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] cancel(input logic [3:0] h);
    logic [3:0] d;
    d = h;
    if (h[3] && h[2]) d[3:2] = 2'b00;
    if (h[1] && h[0]) d[1:0] = 2'b00;
    return d;
  endfunction

  task automatic model_reset();
    m_held    = 4'b0000;
    m_last_kc = 16'h0000;
    m_dir     = 4'b0000;
    m_n       = 0;
  endtask

  // Key history rules applied to one new keycode value.
  task automatic model_key(input logic [15:0] kc);
    logic [3:0] nd;
    if (kc != m_last_kc && kc[7:0] != 8'hF0 && kc[7:0] != 8'hE0) begin
      for (int i = 0; i < 4; i++) begin
        if (kc[7:0] == key_codes[i]) begin
          if (kc[15:8] == 8'hF0) m_held[3-i] = 1'b0;
          else                   m_held[3-i] = 1'b1;
        end
      end
    end
    m_last_kc = kc;
    nd = cancel(m_held);
    if (nd != m_dir) m_n = 0;
    m_dir = nd;
  endtask

  // Frames elapsed since the direction settled decide whether this tick moves.
  function automatic logic [3:0] model_tick();
    logic pulse;
    pulse = 1'b0;
    if (m_dir != 4'b0000) begin
      m_n++;
      pulse = (m_n == 1) || (m_n >= 1 + D && ((m_n - 1 - D) % P) == 0);
    end
    return (pulse && m_en) ? m_dir : 4'b0000;
  endfunction

  task automatic drive_key(input logic [15:0] kc);
    @(negedge clk);
    keycode = kc;
    model_key(kc);
    repeat (3) @(negedge clk);
    chk("held", {28'd0, held}, {28'd0, m_held});
    chk("idle_move", {28'd0, mv}, 32'd0);
  endtask

  task automatic press(input int k);
    drive_key({8'h00, key_codes[k]});
  endtask

  task automatic release_key(input int k);
    drive_key({m_last_kc[7:0], 8'hF0});
    drive_key({8'hF0, key_codes[k]});
  endtask

  task automatic set_enable(input logic e);
    @(negedge clk);
    enable = e;
    m_en   = e;
  endtask

  task automatic do_tick(output logic [3:0] got);
    logic [3:0] exp;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    exp = model_tick();
    chk("move", {28'd0, mv}, {28'd0, exp});
    got = mv;
    @(negedge clk);
    chk("move_width", {28'd0, mv}, 32'd0);
  endtask

  task automatic ticks(input int n);
    logic [3:0] g;
    for (int i = 0; i < n; i++) do_tick(g);
  endtask

  initial begin
    logic [3:0]  g;
    logic [31:0] hits;
    int          cnt;

    key_codes[0] = 8'h1D;
    key_codes[1] = 8'h1B;
    key_codes[2] = 8'h1C;
    key_codes[3] = 8'h23;
    rst        = 1'b0;
    keycode    = 16'h0000;
    frame_tick = 1'b0;
    enable     = 1'b1;
    m_en       = 1'b1;
    model_reset();

    // Reset held with frame ticks running.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      chk("rst_move", {28'd0, mv}, 32'd0);
      chk("rst_held", {28'd0, held}, 32'd0);
    end
    @(negedge clk) rst = 1'b1;
    ticks(3);
    chk("post_rst_held", {28'd0, held}, 32'd0);

    // W held for 30 frames: moves on frames 1, 21, 25, 29.
    press(0);
    hits = 32'd0;
    cnt  = 0;
    for (int t = 1; t <= 30; t++) begin
      do_tick(g);
      if (g != 4'b0000) begin
        hits[t] = 1'b1;
        cnt++;
      end
      if (g != 4'b0000) chk("w_only_up", {28'd0, g}, 32'h8);
    end
    chk("w_pulse_frames", hits, 32'h2220_0002);
    chk("w_pulse_count", cnt, 32'd4);

    // Release W.
    release_key(0);
    chk("w_released", {31'd0, held[3]}, 32'd0);
    ticks(6);

    // Opposing W+S: nothing moves; releasing S restarts up.
    press(0);
    press(1);
    chk("opp_held", {28'd0, held}, 32'hC);
    ticks(5);
    release_key(1);
    do_tick(g);
    chk("opp_restart", {28'd0, g}, 32'h8);
    ticks(24);

    // Add D while W is repeating: diagonal pulse, then delay restarts.
    press(3);
    do_tick(g);
    chk("diag_first", {28'd0, g}, 32'h9);
    ticks(D);

    // enable=0 masks pulses for 10 frames; schedule continues afterwards.
    release_key(3);
    set_enable(1'b0);
    ticks(10);
    set_enable(1'b1);
    ticks(14);

    // Unknown code and E0 prefix change nothing.
    drive_key(16'h0045);
    drive_key(16'h00E0);
    ticks(5);
    release_key(0);

    // Randomised key / enable / frame activity against the model.
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 5))
        0:       press($urandom_range(0, 3));
        1:       release_key($urandom_range(0, 3));
        2:       drive_key({8'h00, 8'h45});
        3:       drive_key({8'h00, 8'hE0});
        4:       set_enable($urandom_range(0, 3) != 0);
        default: ticks($urandom_range(1, 8));
      endcase
    end
    set_enable(1'b1);

    // Reset in the middle of a sequence.
    press(2);
    ticks(3);
    @(negedge clk);
    rst     = 1'b0;
    keycode = 16'h0000;
    model_reset();
    @(negedge clk);
    chk("midrst_held", {28'd0, held}, 32'd0);
    chk("midrst_move", {28'd0, mv}, 32'd0);
    @(negedge clk) rst = 1'b1;
    ticks(4);
    chk("midrst_after", {28'd0, held}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
